store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_DEPTH, default 8, number of store entries; power of two, at least 2.
REQ-002 Parameter SQ_PTR_W, default 3, equals log2(SQ_DEPTH).
REQ-003 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 enq_valid  input  1  LSU offers an executed store.
REQ-006 enq_addr  input  32  physical word-aligned store address.
REQ-007 enq_data  input  32  store data, already lane-shifted.
REQ-008 enq_be  input  4  byte enables.
REQ-009 enq_ready  output  1  entry available; asserted when the queue is not full and flush is low.
REQ-010 fireStore  input  1  the commit stage retires the oldest uncommitted store.
REQ-011 flush  input  1  pipeline flush, driven from ctrl flushReq.
REQ-012 dc_req_valid  output  1  write request to the data cache.
REQ-013 dc_req_addr  output  32  write address.
REQ-014 dc_req_data  output  32  write data.
REQ-015 dc_req_be  output  4  write byte enables.
REQ-016 dc_req_ready  input  1  data cache accepts the write.
REQ-017 sq_empty  output  1  queue holds no entries at all.
REQ-018 sq_commit_empty  output  1  queue holds no committed, undrained entries.
REQ-019 sq_err  output  1  sticky flag: fireStore arrived with no uncommitted entry.

Function
REQ-020 The queue keeps three pointers, each SQ_PTR_W+1 bits wide with a wrap bit: head (oldest), cmt (first uncommitted entry) and tail (next free slot); the invariant head <= cmt <= tail always holds.
REQ-021 Full is tail-head == SQ_DEPTH; empty is tail == head; the committed count is cmt-head; the uncommitted count is tail-cmt.
REQ-022 Enqueue: on enq_valid && enq_ready, write {addr,data,be} at tail and increment tail in the same edge.
REQ-023 Commit: on fireStore with at least one uncommitted entry, increment cmt by 1; at most one commit per cycle.
REQ-024 fireStore with no uncommitted entry: ignore it, leave all pointers unchanged, and set sq_err until reset.
REQ-025 Drain: dc_req_valid = (cmt != head); dc_req_addr, dc_req_data and dc_req_be come combinationally from the head entry.
REQ-026 Pop: on dc_req_valid && dc_req_ready, increment head.
REQ-027 Once dc_req_valid is asserted, it and the request payload stay stable until accepted; flush never withdraws them.
REQ-028 Flush: set tail to the post-commit value of cmt, discarding all uncommitted entries; committed entries are retained and keep draining.
REQ-029 Commit and flush in the same cycle: the commit takes effect first, so the fired store survives.
REQ-030 Enqueue and flush in the same cycle: no enqueue occurs (enq_ready is already low).
REQ-031 Enqueue, commit and pop may occur in the same cycle; each pointer updates independently.
REQ-032 Full queue with a simultaneous pop: enqueue is not accepted that cycle; there is no same-cycle bypass.
REQ-033 A pop of the last committed entry while fireStore is high leaves dc_req_valid high in the next cycle.
REQ-034 Pointer arithmetic wraps modulo 2*SQ_DEPTH; the entry index is ptr[SQ_PTR_W-1:0].
REQ-035 Latency: an entry committed in cycle N may drive dc_req_valid in cycle N+1 at the earliest.

Reset
REQ-036 On rst, set head, cmt and tail to 0 and clear sq_err.
REQ-037 During and after reset, dc_req_valid = 0, sq_empty = 1 and sq_commit_empty = 1; enq_ready = 1 in the first cycle after reset deasserts.
REQ-038 Reset mid-operation discards every entry, including committed ones; entry storage is not cleared.
REQ-039 rst overrides enqueue, fireStore, flush and pop in the same cycle.

Structure
REQ-040 typedef sq_entry_t {addr[31:0], data[31:0], be[3:0]} and the SQ_DEPTH default live in the shared defines package.
REQ-041 Entry storage is a flat register array inside the block, with no sub-module; pointer and flag logic sit in one always_ff block, and the handshake outputs come from one always_comb block.

Verification
REQ-042 Scenario 1: enqueue 3 stores (addr 0x100/0x104/0x108), fireStore twice, dc_req_ready=1 -> exactly two dc writes, 0x100 then 0x104; sq_commit_empty=1; sq_empty=0.
REQ-043 Scenario 2: with 2 committed and 3 uncommitted entries, pulse flush -> tail==cmt, both committed stores still drain, and sq_empty=1 afterwards.
REQ-044 Scenario 3: fireStore and flush in the same cycle with 1 uncommitted entry (addr 0x200) -> entry 0x200 is written to the dcache.
REQ-045 Scenario 4: fill 8 entries -> enq_ready=0; commit one and pop it with ready=1 -> enq_ready=1 the next cycle; 20 enqueue/commit/pop rounds cover pointer wrap with no data mismatch.
REQ-046 Scenario 5: fireStore on an empty queue -> sq_err=1 and it stays set; pointers unchanged; rst clears sq_err.
REQ-047 Scenario 6: hold dc_req_ready=0 for 5 cycles, applying flush in cycle 2 -> dc_req_valid and payload stay stable, and the write completes when ready rises.

Source files
------------

// File: rtl/store_queue_pkg.sv
// Shared definitions for the store queue: entry payload layout and default depth.
package store_queue_pkg;

  localparam int unsigned SQ_DEPTH_DEF = 8;
  localparam int unsigned SQ_ADDR_W    = 32;
  localparam int unsigned SQ_DATA_W    = 32;
  localparam int unsigned SQ_BE_W      = 4;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

endpackage

// File: rtl/store_queue.sv
// In-order store queue: stores enter uncommitted, are committed by the retire stage
// and drain from the head to the data cache; flush drops only uncommitted stores.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = SQ_DEPTH_DEF,
  parameter int unsigned SQ_PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_valid,
  input  logic [31:0] enq_addr,
  input  logic [31:0] enq_data,
  input  logic [3:0]  enq_be,
  output logic        enq_ready,
  input  logic        fireStore,
  input  logic        flush,
  output logic        dc_req_valid,
  output logic [31:0] dc_req_addr,
  output logic [31:0] dc_req_data,
  output logic [3:0]  dc_req_be,
  input  logic        dc_req_ready,
  output logic        sq_empty,
  output logic        sq_commit_empty,
  output logic        sq_err
);

  localparam int unsigned PTR_W = SQ_PTR_W + 1;

  sq_entry_t        entries [SQ_DEPTH];
  sq_entry_t        head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] cmt;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cmt_next;
  logic             full;
  logic             commit_ok;
  logic             enq_fire;
  logic             pop;

  // Handshake and status decode; outputs are forced idle while reset is held.
  always_comb begin
    full            = (tail - head) == PTR_W'(SQ_DEPTH);
    commit_ok       = fireStore && (tail != cmt);
    cmt_next        = cmt + PTR_W'(commit_ok);
    enq_ready       = !rst && !full && !flush;
    enq_fire        = enq_valid && enq_ready;
    dc_req_valid    = !rst && (cmt != head);
    pop             = dc_req_valid && dc_req_ready;
    sq_empty        = rst || (tail == head);
    sq_commit_empty = rst || (cmt == head);
    head_entry      = entries[head[SQ_PTR_W-1:0]];
    dc_req_addr     = head_entry.addr;
    dc_req_data     = head_entry.data;
    dc_req_be       = head_entry.be;
  end

  // Entry storage is never cleared; validity is carried only by the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      entries[tail[SQ_PTR_W-1:0]] <= '{addr: enq_addr, data: enq_data, be: enq_be};
    end
  end

  // Flush rewinds tail to the post-commit cmt so a store fired this cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      cmt    <= '0;
      tail   <= '0;
      sq_err <= 1'b0;
    end else begin
      head <= head + PTR_W'(pop);
      cmt  <= cmt_next;
      if (flush) begin
        tail <= cmt_next;
      end else if (enq_fire) begin
        tail <= tail + PTR_W'(1);
      end
      if (fireStore && !commit_ok) begin
        sq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: a reference queue model feeds a scoreboard of expected
// dcache writes, checked by an independent monitor on the falling clock edge.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_be;
  logic        enq_ready;
  logic        fireStore;
  logic        flush;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic [3:0]  dc_req_be;
  logic        dc_req_ready;
  logic        sq_empty;
  logic        sq_commit_empty;
  logic        sq_err;

  int total  = 0;
  int bad    = 0;
  int writes = 0;

  logic [67:0] exp_q[$];
  logic [67:0] pend[$];
  logic [67:0] mon_e;

  store_queue #(.SQ_DEPTH(8), .SQ_PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_be(enq_be),
    .enq_ready(enq_ready), .fireStore(fireStore), .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_req_be(dc_req_be), .dc_req_ready(dc_req_ready),
    .sq_empty(sq_empty), .sq_commit_empty(sq_commit_empty), .sq_err(sq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] mk(input logic [31:0] a);
    return {a, a ^ 32'hDEAD_BEEF, a[5:2] | 4'b0001};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted dcache write must match the oldest expected store.
  always @(negedge clk) begin
    if (!rst && dc_req_valid && dc_req_ready) begin
      writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%h required=none",
                 {dc_req_addr, dc_req_data, dc_req_be});
      end else begin
        mon_e = exp_q.pop_front();
        chk("dc_write", {dc_req_addr, dc_req_data, dc_req_be}, mon_e);
      end
    end
  end

  // One clock of stimulus; the model commits first, then flushes, then enqueues.
  task automatic cyc(input logic en, input logic [31:0] a, input logic fire,
                     input logic fl, input logic rdy);
    logic [67:0] v;
    logic        full;
    logic        exp_rdy;
    v = mk(a);
    @(posedge clk); #1;
    enq_valid    = en;
    enq_addr     = v[67:36];
    enq_data     = v[35:4];
    enq_be       = v[3:0];
    fireStore    = fire;
    flush        = fl;
    dc_req_ready = rdy;
    full    = (exp_q.size() + pend.size()) == 8;
    exp_rdy = !full && !fl;
    #1;
    chk("enq_ready", 68'(enq_ready), 68'(exp_rdy));
    if (fire && pend.size() > 0) exp_q.push_back(pend.pop_front());
    if (fl) pend.delete();
    if (en && exp_rdy) pend.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enq_valid = 1'b0; fireStore = 1'b0; flush = 1'b0; dc_req_ready = 1'b0;
    enq_addr = '0; enq_data = '0; enq_be = '0;
    @(negedge clk);
    chk("rst_valid", 68'(dc_req_valid), 68'(1'b0));
    chk("rst_empty", 68'(sq_empty), 68'(1'b1));
    chk("rst_commit_empty", 68'(sq_commit_empty), 68'(1'b1));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    pend.delete();
    writes = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout actual=%0d required=0", name, exp_q.size());
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enq_valid = 1'b0; fireStore = 1'b0; flush = 1'b0; dc_req_ready = 1'b0;
    enq_addr = '0; enq_data = '0; enq_be = '0;

    // Scenario 1: three stores, two commits, exactly two writes in order
    do_reset();
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h108, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drain("s1");
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("s1_writes", 68'(writes), 68'(2));
    chk("s1_commit_empty", 68'(sq_commit_empty), 68'(1'b1));
    chk("s1_empty", 68'(sq_empty), 68'(1'b0));

    // Scenario 2: flush keeps two committed stores, drops three uncommitted
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s2_valid", 68'(dc_req_valid), 68'(1'b1));
    chk("s2_commit_empty", 68'(sq_commit_empty), 68'(1'b0));
    drain("s2");
    chk("s2_writes", 68'(writes), 68'(2));
    chk("s2_empty", 68'(sq_empty), 68'(1'b1));

    // Scenario 3: commit and flush together, fired store survives
    do_reset();
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain("s3");
    chk("s3_writes", 68'(writes), 68'(1));
    chk("s3_empty", 68'(sq_empty), 68'(1'b1));

    // Scenario 4: full, pop-no-bypass, then wrapping rounds
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s4_full_ready", 68'(enq_ready), 68'(1'b0));
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h4F0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s4_ready_after_pop", 68'(enq_ready), 68'(1'b1));
    for (int r = 0; r < 20; r++) cyc(1'b1, 32'h800 + 32'(4 * r), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12 && pend.size() > 0; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drain("s4");
    chk("s4_empty", 68'(sq_empty), 68'(1'b1));

    // Scenario 5: sticky error on fire with nothing uncommitted
    do_reset();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s5_err", 68'(sq_err), 68'(1'b1));
    chk("s5_empty", 68'(sq_empty), 68'(1'b1));
    chk("s5_valid", 68'(dc_req_valid), 68'(1'b0));
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("s5_err_sticky", 68'(sq_err), 68'(1'b1));
    cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drain("s5");
    chk("s5_writes", 68'(writes), 68'(1));
    do_reset();
    chk("s5_err_cleared", 68'(sq_err), 68'(1'b0));

    // Scenario 6: request held stable through backpressure and a flush
    do_reset();
    cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 32'h0, 1'b0, c == 1, 1'b0);
      chk("s6_valid", 68'(dc_req_valid), 68'(1'b1));
      chk("s6_payload", {dc_req_addr, dc_req_data, dc_req_be}, mk(32'h600));
    end
    drain("s6");
    chk("s6_writes", 68'(writes), 68'(1));
    chk("s6_empty", 68'(sq_empty), 68'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
